// File: rtl/spi_bus_arb_pkg.sv
// Shared types for the register-bus arbiter: sequencer states, grant width, pointer wrap helper.
package spi_bus_arb_pkg;

  localparam int unsigned GRANT_W = 3;

  // ST_DRAIN is only reachable when SPI_BUS_ARB_TIMEOUT_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] v,
                                                  input int unsigned n);
    int unsigned t;
    t = 32'(v);
    t = (t + 1) % n;
    return t[GRANT_W-1:0];
  endfunction

endpackage

// File: rtl/spi_bus_arb_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping mod N_SRC.
module rr_pick
  import spi_bus_arb_pkg::*;
#(
  parameter int unsigned N_SRC = 2
) (
  input  logic [N_SRC-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               valid,
  output logic [GRANT_W-1:0] idx
);

  logic               hi_valid;
  logic               lo_valid;
  logic [GRANT_W-1:0] hi_idx;
  logic [GRANT_W-1:0] lo_idx;
  int unsigned        ptr_i;

  // Two ascending scans: indices at/after ptr take priority over the wrapped ones below it.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    ptr_i    = 32'(ptr);
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i]) begin
        if (i >= ptr_i) begin
          if (!hi_valid) begin
            hi_valid = 1'b1;
            hi_idx   = i[GRANT_W-1:0];
          end
        end else if (!lo_valid) begin
          lo_valid = 1'b1;
          lo_idx   = i[GRANT_W-1:0];
        end
      end
    end
    valid = hi_valid | lo_valid;
    idx   = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/spi_bus_arb.sv
// Frame-atomic round-robin arbiter/sequencer for the byte-wide register bus.
// Optional mid-frame idle timeout with drain: define SPI_BUS_ARB_TIMEOUT_EN.
module spi_bus_arb
  import spi_bus_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   s_valid,
  output logic [N_SRC-1:0]   s_ready,
  input  logic [8*N_SRC-1:0] s_data,
  input  logic [N_SRC-1:0]   s_last,
  output logic [7:0]         bus_addr,
  output logic [7:0]         bus_data,
  output logic               bus_first,
  output logic               bus_strobe,
  output logic [GRANT_W-1:0] grant,
  output logic               busy,
  output logic               aborted
);

  if (N_SRC == 0 || N_SRC > 8 || TIMEOUT == 0) begin : g_param_check
    $error("spi_bus_arb: N_SRC must be 1..8 and TIMEOUT at least 1");
  end

  state_t             state;
  state_t             state_nx;
  logic [GRANT_W-1:0] ptr;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_valid;
  logic               accept;
  logic               acc_last;
  logic [7:0]         sel_byte;
  logic               first_pend;
  logic               timeout_hit;
  logic               frame_end;

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req   (s_valid),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the granted bit of s_ready can be set, so this collapses to the granted lane.
  always_comb begin
    accept   = 1'b0;
    acc_last = 1'b0;
    sel_byte = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (s_ready[i]) begin
        accept   = s_valid[i];
        acc_last = s_valid[i] & s_last[i];
        sel_byte = s_data[8*i +: 8];
      end
    end
  end

`ifdef SPI_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             stalling;

  assign stalling    = ((state == ST_ADDR) || (state == ST_DATA)) && !accept;
  assign timeout_hit = stalling && (to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           to_cnt <= '0;
    else if (stalling) to_cnt <= to_cnt + CNT_W'(1);
    else               to_cnt <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (pick_valid) state_nx = ST_ADDR;
      ST_ADDR: begin
        if (accept)           state_nx = acc_last ? ST_IDLE : ST_DATA;
        else if (timeout_hit) state_nx = ST_DRAIN;
      end
      ST_DATA: begin
        if (accept && acc_last) state_nx = ST_IDLE;
        else if (timeout_hit)   state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (accept && acc_last) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = '0;
    busy    = (state != ST_IDLE);
    if (state != ST_IDLE) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        s_ready[i] = (grant == i[GRANT_W-1:0]);
      end
    end
  end

  assign frame_end = (state != ST_IDLE) && (state_nx == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      ptr        <= '0;
      bus_addr   <= '0;
      bus_data   <= '0;
      bus_first  <= 1'b0;
      bus_strobe <= 1'b0;
      first_pend <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      bus_strobe <= 1'b0;
      aborted    <= timeout_hit;
      if ((state == ST_IDLE) && pick_valid) grant <= pick_idx;
      if (frame_end) ptr <= wrap_inc(grant, N_SRC);
      if ((state == ST_ADDR) && accept) begin
        bus_addr   <= sel_byte;
        first_pend <= 1'b1;
      end
      if ((state == ST_DATA) && accept) begin
        bus_data   <= sel_byte;
        bus_strobe <= 1'b1;
        bus_first  <= first_pend;
        first_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_arb.sv
// Self-checking bench for spi_bus_arb: frame-level reference model with per-source byte queues.
module tb_spi_bus_arb;
  import spi_bus_arb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 8;
`ifdef SPI_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       s_valid = '0;
  logic [N-1:0]       s_ready;
  logic [8*N-1:0]     s_data = '0;
  logic [N-1:0]       s_last = '0;
  logic [7:0]         bus_addr;
  logic [7:0]         bus_data;
  logic               bus_first;
  logic               bus_strobe;
  logic [GRANT_W-1:0] grant;
  logic               busy;
  logic               aborted;

  spi_bus_arb #(.N_SRC(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_first  (bus_first),
    .bus_strobe (bus_strobe),
    .grant      (grant),
    .busy       (busy),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  qd[N][$];
  logic        ql[N][$];
  bit          at_start[N];
  bit          m_active;
  bit          m_drain;
  int unsigned m_src;
  int unsigned m_pos;
  int unsigned m_ptr;
  int unsigned m_stall;
  logic [7:0]  m_addr;
  logic [7:0]  exp_data;
  logic        exp_first;
  logic        exp_strobe;
  logic        exp_abort;
  int unsigned stall_pos;
  int unsigned stall_left;
  bit          rand_stall;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int unsigned i = 0; i < N; i++) begin
      qd[i].delete();
      ql[i].delete();
      at_start[i] = 1'b1;
    end
    m_active = 1'b0; m_drain = 1'b0; m_src = 0; m_pos = 0; m_ptr = 0; m_stall = 0;
    m_addr = '0; exp_data = '0; exp_first = 1'b0; exp_strobe = 1'b0; exp_abort = 1'b0;
    stall_pos = 0; stall_left = 0; rand_stall = 1'b0;
  endfunction

  function automatic bit pending();
    bit p;
    p = m_active;
    for (int unsigned i = 0; i < N; i++) if (qd[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic push(input int unsigned src, input logic [7:0] b, input logic l);
    qd[src].push_back(b);
    ql[src].push_back(l);
  endtask

  // A source always offers the first byte of a frame; mid-frame it may stall.
  task automatic drive();
    for (int unsigned i = 0; i < N; i++) begin
      if (qd[i].size() > 0) begin
        logic v;
        s_data[8*i +: 8] = qd[i][0];
        s_last[i]        = ql[i][0];
        v = at_start[i] ? 1'b1 : (rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (stall_left > 0 && m_active && m_src == i && m_pos == stall_pos) begin
          v = 1'b0;
          stall_left--;
        end
        s_valid[i] = v;
      end else begin
        s_valid[i]       = 1'b0;
        s_data[8*i +: 8] = 8'($urandom);
        s_last[i]        = 1'($urandom);
      end
    end
  endtask

  task automatic model_step();
    exp_strobe = 1'b0;
    exp_abort  = 1'b0;
    if (m_active) begin
      if (s_valid[m_src]) begin
        logic [7:0] b;
        logic       l;
        b = qd[m_src].pop_front();
        l = ql[m_src].pop_front();
        at_start[m_src] = l;
        m_stall = 0;
        if (!m_drain) begin
          if (m_pos == 0) m_addr = b;
          else begin
            exp_strobe = 1'b1;
            exp_data   = b;
            exp_first  = (m_pos == 1);
          end
        end
        m_pos++;
        if (l) begin
          m_active = 1'b0;
          m_drain  = 1'b0;
          m_ptr    = (m_src + 1) % N;
        end
      end else if (TO_EN && !m_drain) begin
        m_stall++;
        if (m_stall == TO) begin
          exp_abort = 1'b1;
          m_drain   = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        int unsigned j;
        j = (m_ptr + k) % N;
        if (!m_active && s_valid[j]) begin
          m_active = 1'b1; m_src = j; m_pos = 0; m_stall = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] exp_ready;
    @(posedge clk); #1;
    chk("bus_strobe", 32'(bus_strobe), 32'(exp_strobe));
    chk("bus_data",   32'(bus_data),   32'(exp_data));
    chk("bus_first",  32'(bus_first),  32'(exp_first));
    chk("bus_addr",   32'(bus_addr),   32'(m_addr));
    chk("aborted",    32'(aborted),    32'(exp_abort));
    exp_ready = '0;
    if (m_active) exp_ready[m_src] = 1'b1;
    chk("s_ready", 32'(s_ready), 32'(exp_ready));
    chk("busy",    32'(busy),    32'(m_active));
    if (m_active) chk("grant", 32'(grant), m_src);
    drive();
    model_step();
  endtask

  task automatic run(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    vectors++;
    assert (n < budget) else begin
      miscompares++;
      $error("FAIL budget: still pending after %0d cycles, required under %0d", n, budget);
    end
    cycle();
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready",    32'(s_ready),    32'd0);
    chk("rst_bus_addr",   32'(bus_addr),   32'd0);
    chk("rst_bus_data",   32'(bus_data),   32'd0);
    chk("rst_bus_first",  32'(bus_first),  32'd0);
    chk("rst_bus_strobe", 32'(bus_strobe), 32'd0);
    chk("rst_grant",      32'(grant),      32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_aborted",    32'(aborted),    32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Basic frame: address then two data strobes, first flag on the first only.
    push(0, 8'h12, 1'b0); push(0, 8'hAB, 1'b0); push(0, 8'hCD, 1'b1);
    run(50);

    // Two frames per source queued together: rotation between src0 and src1.
    push(0, 8'h21, 1'b0); push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
    push(0, 8'h22, 1'b0); push(0, 8'h05, 1'b1);
    push(1, 8'h31, 1'b0); push(1, 8'h03, 1'b0); push(1, 8'h04, 1'b1);
    push(1, 8'h32, 1'b0); push(1, 8'h06, 1'b1);
    run(80);

    // Address-only frame.
    push(0, 8'h40, 1'b1);
    run(20);

    // Mid-frame stall of 5 cycles with another source waiting.
    stall_pos = 2; stall_left = 5;
    push(0, 8'h50, 1'b0); push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    push(1, 8'h51, 1'b0); push(1, 8'h07, 1'b1);
    run(60);

    // Asynchronous reset in the middle of a data phase.
    push(0, 8'h60, 1'b0); push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0);
    push(0, 8'h63, 1'b0); push(0, 8'h64, 1'b1);
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    s_valid = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    push(1, 8'h70, 1'b0); push(1, 8'h09, 1'b0); push(1, 8'h0A, 1'b1);
    push(2, 8'h71, 1'b1);
    run(50);

`ifdef SPI_BUS_ARB_TIMEOUT_EN
    // Stall past the timeout: abort pulse, remaining bytes drained silently.
    stall_pos = 2; stall_left = TO;
    push(0, 8'h10, 1'b0); push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    push(1, 8'h11, 1'b0); push(1, 8'h0E, 1'b1);
    run(80);
`endif

    // Randomized batches of frames across all sources with mid-frame stalls.
    rand_stall = 1'b1;
    for (int unsigned batch = 0; batch < 25; batch++) begin
      for (int unsigned src = 0; src < N; src++) begin
        int unsigned nf;
        nf = $urandom_range(0, 3);
        for (int unsigned f = 0; f < nf; f++) begin
          int unsigned len;
          len = $urandom_range(1, 5);
          for (int unsigned k = 0; k < len; k++) push(src, 8'($urandom), (k == len - 1));
        end
      end
      run(600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
